seq_det_sched: RTL and testbench
================================

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter NCH, default 4, number of serial input channels sharing one detector; legal range 2..8.
REQ-002 Parameter CNTW, default 8, width of each per-channel match counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scheduler enable; low means no grants and all contexts are held.
REQ-006 ch_valid  input  NCH  per-channel flag: a serial bit is offered this cycle.
REQ-007 ch_bit  input  NCH  per-channel serial data bit, qualified by ch_valid.
REQ-008 ch_ready  output  NCH  one-hot grant; the bit of channel g is consumed when ch_valid[g] and ch_ready[g] are both high.
REQ-009 ch_clr  input  NCH  per-channel synchronous context flush.
REQ-010 cnt_clr  input  1  synchronous clear of all match counters.
REQ-011 match_valid  output  1  registered pulse: the granted channel's detector entered the match state.
REQ-012 match_ch  output  $clog2(NCH)  channel index for match_valid; holds its last value otherwise.
REQ-013 rd_sel  input  $clog2(NCH)  counter read select.
REQ-014 rd_cnt  output  CNTW  combinational read of the selected channel's match counter.

Function
REQ-015 One shared overlapping Moore "1010" detector step SHALL serve all channels by time-multiplexing, with one 3-bit state context stored per channel.
REQ-016 Detector states SHALL be S_IDLE, S_1, S_10, S_101 and S_1010; the match output is asserted only in S_1010.
REQ-017 Transitions on x=0/x=1 SHALL be: IDLE->IDLE/S_1; S_1->S_10/S_1; S_10->IDLE/S_101; S_101->S_1010/S_1; S_1010->IDLE/S_101 (overlap).
REQ-018 An unencoded context value SHALL step to S_IDLE.
REQ-019 Eligible channels SHALL be those with en=1, ch_valid[g]=1 and ch_clr[g]=0.
REQ-020 Arbitration SHALL be round-robin among eligible channels: search starts at last_grant+1 modulo NCH; at most one grant per cycle.
REQ-021 ch_ready SHALL be combinational from the eligibility inputs and last_grant, with no combinational path from ch_bit.
REQ-022 last_grant SHALL update only on a cycle with a grant.
REQ-023 On a grant to g in cycle t, ctx[g] SHALL be updated at the edge ending t; match_valid/match_ch SHALL reflect that update in cycle t+1 (latency 1).
REQ-024 match_valid SHALL be 1 for exactly one cycle per grant whose next state is S_1010, and 0 otherwise.
REQ-025 On each match, cnt[g] SHALL increment by 1, saturating at 2^CNTW-1 with no wrap.
REQ-026 ch_clr[g] SHALL set ctx[g] to S_IDLE at the next edge; a channel under clear is never granted, so its offered bit is not consumed.
REQ-027 cnt_clr SHALL zero all counters; if cnt_clr and a match increment occur in the same cycle, the clear wins.
REQ-028 Ungranted channels SHALL keep their contexts unchanged, regardless of ch_bit.
REQ-029 Deasserting en mid-stream SHALL preserve all contexts, counters and last_grant.

Reset
REQ-030 While rst_n=0, all ctx SHALL be S_IDLE, all cnt 0, last_grant NCH-1 (so channel 0 has first priority), match_valid 0 and match_ch 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight match pulse.

Structure
REQ-032 A shared package seq_det_pkg SHALL hold the state enum type (3-bit) and the state constants.
REQ-033 The next-state/match function SHALL be one sub-module, seq_det_step (inputs: state, x; outputs: next state, match), instantiated once.

Verification
REQ-034 Single channel 0 streams 1,0,1,0,1,0: match_valid at cycles after the 4th and 6th bits, match_ch=0, cnt[0]=2.
REQ-035 All 4 channels valid every cycle: grant order 0,1,2,3,0,...; each channel streams 1010 interleaved, giving 4 matches on consecutive cycles with match_ch 0,1,2,3.
REQ-036 Channel 1 receives 1,0,1, then ch_clr[1] pulses, then 0: no match, and ctx[1] steps S_IDLE->S_IDLE.
REQ-037 Channel 2 produces 300 matches with CNTW=8: rd_sel=2 gives rd_cnt=255; cnt_clr coincident with a match gives rd_cnt=0.
REQ-038 en=0 for 5 cycles between bits "101" and "0" on channel 3: ch_ready=0 throughout, and the match still occurs after the final 0.
REQ-039 rst_n asserted on the cycle after the final 0 of a pattern: match_valid stays 0, all counters read 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types for the time-multiplexed "1010" sequence detector.
// The state encoding is fixed at 3 bits so a per-channel context is one
// small register, and values 5..7 are deliberately unused (they recover
// to S_IDLE in the step function).
package seq_det_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1010 = 3'd4
  } det_state_e;

endpackage

// File: rtl/seq_det_step.sv
// One combinational step of the overlapping Moore "1010" detector.
// The caller supplies a raw stored context (which may be an unencoded value
// after an upset) and the input bit; the step returns the next state and the
// Moore output of that next state (high only when it is S_1010).
module seq_det_step
  import seq_det_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               x,
  output det_state_e         next_state,
  output logic               match
);

  // Next-state table; any unencoded context falls back to S_IDLE.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE: next_state = x ? S_1   : S_IDLE;
      S_1:    next_state = x ? S_1   : S_10;
      S_10:   next_state = x ? S_101 : S_IDLE;
      S_101:  next_state = x ? S_1   : S_1010;
      S_1010: next_state = x ? S_101 : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore output of the destination state.
  assign match = (next_state == S_1010);

endmodule

// File: rtl/seq_det_sched.sv
// Multi-channel "1010" detector: NCH serial channels share one detector
// step through a round-robin scheduler. Each channel keeps its own 3-bit
// detector context and a saturating match counter.
//
// Handshake: channel g offers a bit by raising ch_valid[g]; the bit is
// consumed only in a cycle where ch_valid[g] and ch_ready[g] are both high.
// ch_ready is one-hot (or all zero), depends only on en/ch_valid/ch_clr and
// the last grant, never on ch_bit, and a source must hold its bit until it
// is consumed.
//
// dbg_ctx exposes the stored detector context of the channel picked by
// rd_sel so checkers can observe every channel's FSM state.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CNTW = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NCH-1:0]     ch_valid,
  input  logic [NCH-1:0]     ch_bit,
  output logic [NCH-1:0]     ch_ready,
  input  logic [NCH-1:0]     ch_clr,
  input  logic               cnt_clr,
  output logic               match_valid,
  output logic [SELW-1:0]    match_ch,
  input  logic [SELW-1:0]    rd_sel,
  output logic [CNTW-1:0]    rd_cnt,
  output logic [STATE_W-1:0] dbg_ctx
);

  logic [STATE_W-1:0] ctx [NCH];
  logic [CNTW-1:0]    cnt [NCH];
  logic [SELW-1:0]    last_grant;

  logic [NCH-1:0]     elig;
  logic               gnt_any;
  logic [SELW-1:0]    gnt_idx;
  logic [SELW-1:0]    cand_idx;
  int                 cand;

  logic [STATE_W-1:0] cur_state;
  logic               cur_bit;
  det_state_e         step_next;
  logic               step_match;

  // A channel under flush is never eligible, so its offered bit stays pending.
  assign elig = en ? (ch_valid & ~ch_clr) : '0;

  // Round-robin pick: scan from last_grant+1, wrapping, first eligible wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand     = (int'(last_grant) + i) % NCH;
      cand_idx = SELW'(cand);
      if (!gnt_any && elig[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // One-hot grant vector derived from the pick.
  always_comb begin
    ch_ready = '0;
    if (gnt_any) ch_ready[gnt_idx] = 1'b1;
  end

  // Present the granted channel's context and bit to the shared step.
  always_comb begin
    cur_state = ctx[gnt_idx];
    cur_bit   = ch_bit[gnt_idx];
  end

  seq_det_step u_step (
    .state      (cur_state),
    .x          (cur_bit),
    .next_state (step_next),
    .match      (step_match)
  );

  // Context store: flush wins, else only the granted channel advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NCH; g++) ctx[g] <= S_IDLE;
    end else begin
      for (int g = 0; g < NCH; g++) begin
        if (ch_clr[g]) begin
          ctx[g] <= S_IDLE;
        end else if (gnt_any && (gnt_idx == SELW'(g))) begin
          ctx[g] <= step_next;
        end
      end
    end
  end

  // Saturating match counters; a global clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NCH; g++) cnt[g] <= '0;
    end else begin
      for (int g = 0; g < NCH; g++) begin
        if (cnt_clr) begin
          cnt[g] <= '0;
        end else if (gnt_any && step_match && (gnt_idx == SELW'(g)) &&
                     (cnt[g] != {CNTW{1'b1}})) begin
          cnt[g] <= cnt[g] + CNTW'(1);
        end
      end
    end
  end

  // Registered match pulse; match_ch holds the last matching channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= gnt_any & step_match;
      if (gnt_any && step_match) match_ch <= gnt_idx;
    end
  end

  // Arbiter pointer; reset value makes channel 0 the first choice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SELW'(NCH - 1);
    end else if (gnt_any) begin
      last_grant <= gnt_idx;
    end
  end

  // Read-side muxes for counter and debug context; out-of-range selects read 0.
  always_comb begin
    rd_cnt  = '0;
    dbg_ctx = '0;
    if (int'(rd_sel) < NCH) begin
      rd_cnt  = cnt[rd_sel];
      dbg_ctx = ctx[rd_sel];
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched (NCH=4, CNTW=8).
module tb_seq_det_sched;

  localparam int NCH  = 4;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [NCH-1:0]  ch_valid;
  logic [NCH-1:0]  ch_bit;
  logic [NCH-1:0]  ch_ready;
  logic [NCH-1:0]  ch_clr;
  logic            cnt_clr;
  logic            match_valid;
  logic [1:0]      match_ch;
  logic [1:0]      rd_sel;
  logic [CNTW-1:0] rd_cnt;
  logic [2:0]      dbg_ctx;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  seq_det_sched #(.NCH(NCH), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .ch_clr      (ch_clr),
    .cnt_clr     (cnt_clr),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .rd_sel      (rd_sel),
    .rd_cnt      (rd_cnt),
    .dbg_ctx     (dbg_ctx)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_valid = '0;
    ch_bit   = '0;
    ch_clr   = '0;
    cnt_clr  = 1'b0;
    en       = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // drive one bit on a single channel, check grant, then check the pulse
  task automatic send_bit(input int ch, input logic b, input logic exp_mv, input string tag);
    ch_valid = 4'b0001 << ch;
    ch_bit   = 4'(b) << ch;
    #1;
    check({tag, "_ready"}, 32'(ch_ready), 32'(4'b0001 << ch));
    tick();
    ch_valid = '0;
    ch_bit   = '0;
    check({tag, "_mv"}, 32'(match_valid), 32'(exp_mv));
    if (exp_mv) check({tag, "_mch"}, 32'(match_ch), 32'(ch));
  endtask

  logic [3:0] pat1 [6];
  logic [3:0] exp1 [6];

  initial begin
    rd_sel = '0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_mv", 32'(match_valid), 0);
    check("rst_mch", 32'(match_ch), 0);
    for (int i = 0; i < NCH; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("rst_cnt%0d", i), 32'(rd_cnt), 0);
      check($sformatf("rst_ctx%0d", i), 32'(dbg_ctx), 0);
    end
    rst_n = 1'b1;
    ch_valid = 4'hF;
    #1;
    check("rst_first_prio", 32'(ch_ready), 32'h1);
    ch_valid = '0;
    tick();

    // single channel 0: 1,0,1,0,1,0 -> pulses after 4th and 6th bits
    pat1 = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    exp1 = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
    for (int k = 0; k < 6; k++)
      send_bit(0, pat1[k][0], exp1[k][0], $sformatf("t1_b%0d", k));
    rd_sel = 2'd0;
    #1;
    check("t1_cnt0", 32'(rd_cnt), 2);

    // all four channels valid every cycle, interleaved 1010
    do_reset();
    for (int t = 0; t < 16; t++) begin
      ch_valid = 4'hF;
      ch_bit   = (((t / 4) % 2) == 0) ? 4'hF : 4'h0;
      #1;
      check($sformatf("t2_ready%0d", t), 32'(ch_ready), 32'(4'b0001 << (t % 4)));
      if (t >= 12) exp_q.push_back(2'(t % 4));
      tick();
      check($sformatf("t2_mv%0d", t), 32'(match_valid), 32'(t >= 12));
      if (match_valid) begin
        if (exp_q.size() > 0) check($sformatf("t2_mch%0d", t), 32'(match_ch), 32'(exp_q.pop_front()));
        else check("t2_extra", 1, 0);
      end
    end
    idle_inputs();
    tick();
    check("t2_mv_after", 32'(match_valid), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);
    for (int i = 0; i < NCH; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("t2_cnt%0d", i), 32'(rd_cnt), 1);
    end

    // channel 1: 1,0,1 then flush, then 0 -> no match
    do_reset();
    rd_sel = 2'd1;
    send_bit(1, 1'b1, 1'b0, "t3_b0");
    send_bit(1, 1'b0, 1'b0, "t3_b1");
    send_bit(1, 1'b1, 1'b0, "t3_b2");
    check("t3_ctx_101", 32'(dbg_ctx), 3);
    ch_valid = 4'b0010;
    ch_bit   = 4'b0000;
    ch_clr   = 4'b0010;
    #1;
    check("t3_clr_ready", 32'(ch_ready), 0);
    tick();
    ch_clr   = '0;
    ch_valid = '0;
    check("t3_clr_mv", 32'(match_valid), 0);
    check("t3_ctx_flushed", 32'(dbg_ctx), 0);
    send_bit(1, 1'b0, 1'b0, "t3_b3");
    check("t3_ctx_idle", 32'(dbg_ctx), 0);
    check("t3_cnt1", 32'(rd_cnt), 0);

    // channel 3: 101, en low 5 cycles, then 0 -> match
    rd_sel = 2'd3;
    send_bit(3, 1'b1, 1'b0, "t4_b0");
    send_bit(3, 1'b0, 1'b0, "t4_b1");
    send_bit(3, 1'b1, 1'b0, "t4_b2");
    for (int k = 0; k < 5; k++) begin
      en       = 1'b0;
      ch_valid = 4'b1000;
      ch_bit   = 4'b0000;
      #1;
      check($sformatf("t4_hold_ready%0d", k), 32'(ch_ready), 0);
      tick();
      check($sformatf("t4_hold_mv%0d", k), 32'(match_valid), 0);
    end
    check("t4_ctx_held", 32'(dbg_ctx), 3);
    en = 1'b1;
    send_bit(3, 1'b0, 1'b1, "t4_b3");
    check("t4_cnt3", 32'(rd_cnt), 1);

    // channel 2: 300 matches saturate at 255, then clear vs match
    do_reset();
    rd_sel = 2'd2;
    for (int k = 0; k < 301; k++) begin
      send_bit(2, 1'b1, 1'b0, "t5_one");
      send_bit(2, 1'b0, (k > 0), "t5_zero");
    end
    #1;
    check("t5_sat", 32'(rd_cnt), 255);
    send_bit(2, 1'b1, 1'b0, "t5_pre");
    cnt_clr = 1'b1;
    send_bit(2, 1'b0, 1'b1, "t5_clrmatch");
    cnt_clr = 1'b0;
    #1;
    check("t5_clr_wins", 32'(rd_cnt), 0);
    send_bit(2, 1'b1, 1'b0, "t5_post1");
    send_bit(2, 1'b0, 1'b1, "t5_post0");
    check("t5_recount", 32'(rd_cnt), 1);

    // channel 0: reset lands while a match pulse is in flight
    rd_sel = 2'd0;
    send_bit(0, 1'b1, 1'b0, "t6_b0");
    send_bit(0, 1'b0, 1'b0, "t6_b1");
    send_bit(0, 1'b1, 1'b0, "t6_b2");
    send_bit(0, 1'b0, 1'b1, "t6_b3");
    check("t6_cnt_before", 32'(rd_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mv", 32'(match_valid), 0);
    for (int i = 0; i < NCH; i++) begin
      rd_sel = 2'(i);
      #1;
      check($sformatf("t6_rst_cnt%0d", i), 32'(rd_cnt), 0);
    end
    tick();
    check("t6_rst_mv_hold", 32'(match_valid), 0);
    rst_n = 1'b1;
    tick();
    check("t6_after_mv", 32'(match_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
